// File: rtl/write_ctrl.sv
// rtl/write_ctrl.sv - M1 write-channel route controller: AW decode, route hold through W/B, WLAST length check.
// Optional built-in default slave for unmapped addresses enabled by defining AXI_DEFSLV_EN.
module write_ctrl #(
  parameter logic [31:0] S1_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_C000,
  parameter logic [31:0] S2_BASE = 32'h0001_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_BASE = 32'h0002_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S4_BASE = 32'h1000_0000,
  parameter logic [31:0] S4_MASK = 32'hFFFF_FC00,
  parameter logic [31:0] S5_BASE = 32'h2000_0000,
  parameter logic [31:0] S5_MASK = 32'hFFE0_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWVALID_M1,
  input  logic [31:0] AWADDR_M1,
  input  logic [3:0]  AWLEN_M1,
  input  logic        AWREADY_M1,
  input  logic        WVALID_M1,
  input  logic        WREADY_M1,
  input  logic        WLAST_M1,
  input  logic        BVALID_M1,
  input  logic        BREADY_M1,
  output logic [3:0]  AW_arbiter,
  output logic        cs_w,
  output logic        busy,
  output logic        len_err,
  output logic        AWREADY_DEF,
  output logic        WREADY_DEF,
  output logic        BVALID_DEF,
  output logic [1:0]  BRESP_DEF
);

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_S1   = 4'b0101;
  localparam logic [3:0] C_S2   = 4'b0111;
  localparam logic [3:0] C_S3   = 4'b1001;
  localparam logic [3:0] C_S4   = 4'b1011;
  localparam logic [3:0] C_S5   = 4'b1101;
  localparam logic [3:0] C_DEF  = 4'b1111;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state, state_n;
  logic [3:0] arb_n;
  logic       cs_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] len_q, len_n;
  logic       lerr_n;
  logic [3:0] dec_code;

  // Windows are checked in priority order; anything unmatched falls to the default code.
  function automatic logic [3:0] decode(input logic [31:0] a);
    if ((a & S1_MASK) == S1_BASE) return C_S1;
    if ((a & S2_MASK) == S2_BASE) return C_S2;
    if ((a & S3_MASK) == S3_BASE) return C_S3;
    if ((a & S4_MASK) == S4_BASE) return C_S4;
    if ((a & S5_MASK) == S5_BASE) return C_S5;
    return C_DEF;
  endfunction

  assign dec_code = decode(AWADDR_M1);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      AW_arbiter <= C_NONE;
      cs_w       <= 1'b0;
      cnt        <= 4'd0;
      len_q      <= 4'd0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_n;
      AW_arbiter <= arb_n;
      cs_w       <= cs_n;
      cnt        <= cnt_n;
      len_q      <= len_n;
      len_err    <= lerr_n;
    end
  end

  always_comb begin
    state_n = state;
    arb_n   = AW_arbiter;
    cs_n    = cs_w;
    cnt_n   = cnt;
    len_n   = len_q;
    lerr_n  = len_err;
    case (state)
      IDLE: begin
        arb_n = C_NONE;
        cs_n  = 1'b0;
`ifdef AXI_DEFSLV_EN
        if (AWVALID_M1) begin
          arb_n   = dec_code;
          state_n = ADDR;
        end
`else
        // Unmapped requests are never routed; the master has to withdraw them.
        if (AWVALID_M1 && dec_code != C_DEF) begin
          arb_n   = dec_code;
          state_n = ADDR;
        end
`endif
      end
      ADDR: begin
        if (AWVALID_M1 && AWREADY_M1) begin
          len_n   = AWLEN_M1;
          cnt_n   = 4'd0;
          cs_n    = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (WVALID_M1 && WREADY_M1) begin
          cnt_n = cnt + 4'd1;
          // cnt still holds the beats before this one, so a correct last beat sees cnt == AWLEN.
          if (WLAST_M1) begin
            if (cnt != len_q) lerr_n = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        if (BVALID_M1 && BREADY_M1) begin
          arb_n   = C_NONE;
          cs_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef AXI_DEFSLV_EN
  logic def_sel;
  assign def_sel     = (AW_arbiter == C_DEF);
  assign AWREADY_DEF = def_sel && (state == ADDR);
  assign WREADY_DEF  = def_sel && (state == DATA);
  assign BVALID_DEF  = def_sel && (state == RESP);
  assign BRESP_DEF   = (def_sel && state == RESP) ? 2'b11 : 2'b00;
`else
  assign AWREADY_DEF = 1'b0;
  assign WREADY_DEF  = 1'b0;
  assign BVALID_DEF  = 1'b0;
  assign BRESP_DEF   = 2'b00;
`endif

endmodule

// File: tb/tb_write_ctrl.sv
// tb/tb_write_ctrl.sv - directed vector bench for write_ctrl.
module tb_write_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID_M1, AWREADY_M1, WVALID_M1, WREADY_M1, WLAST_M1, BVALID_M1, BREADY_M1;
  logic [31:0] AWADDR_M1;
  logic [3:0]  AWLEN_M1;
  logic [3:0]  AW_arbiter;
  logic        cs_w, busy, len_err, AWREADY_DEF, WREADY_DEF, BVALID_DEF;
  logic [1:0]  BRESP_DEF;

  int errors = 0;
  int checks = 0;

  write_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M1(AWVALID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1), .AWREADY_M1(AWREADY_M1),
    .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1), .WLAST_M1(WLAST_M1),
    .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
    .AW_arbiter(AW_arbiter), .cs_w(cs_w), .busy(busy), .len_err(len_err),
    .AWREADY_DEF(AWREADY_DEF), .WREADY_DEF(WREADY_DEF), .BVALID_DEF(BVALID_DEF), .BRESP_DEF(BRESP_DEF)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        av;
    logic [31:0] addr;
    logic [3:0]  len;
    logic        ar, wv, wr, wl, bv, br;
    logic [3:0]  code;
    logic        cs, bsy, lerr;
  } vec_t;

  vec_t vq[$];

  // Observed word: {code, cs_w, busy, len_err, AWREADY_DEF, WREADY_DEF, BVALID_DEF, BRESP_DEF}
  function automatic logic [11:0] obs();
    return {AW_arbiter, cs_w, busy, len_err, AWREADY_DEF, WREADY_DEF, BVALID_DEF, BRESP_DEF};
  endfunction

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = obs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got code=%b cs=%b busy=%b lerr=%b def=%b, expected code=%b cs=%b busy=%b lerr=%b def=%b",
               name, act[11:8], act[7], act[6], act[5], act[4:0], exp[11:8], exp[7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic add(input logic av, input logic [31:0] addr, input logic [3:0] len,
                     input logic ar, input logic wv, input logic wr, input logic wl,
                     input logic bv, input logic br,
                     input logic [3:0] code, input logic cs, input logic bsy, input logic lerr);
    vec_t v;
    v.av = av; v.addr = addr; v.len = len; v.ar = ar; v.wv = wv; v.wr = wr; v.wl = wl;
    v.bv = bv; v.br = br; v.code = code; v.cs = cs; v.bsy = bsy; v.lerr = lerr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [31:0] addr, input logic [3:0] len,
                       input logic ar, input logic wv, input logic wr, input logic wl,
                       input logic bv, input logic br);
    AWVALID_M1 = av; AWADDR_M1 = addr; AWLEN_M1 = len; AWREADY_M1 = ar;
    WVALID_M1 = wv; WREADY_M1 = wr; WLAST_M1 = wl; BVALID_M1 = bv; BREADY_M1 = br;
  endtask

  initial begin
    ARESETn = 1'b0;
    drive(0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 0);

    //   av addr          len ar wv wr wl bv br   code    cs bsy lerr
    // S2 burst, AWLEN=3, 4 beats (one stalled), B stalled once
    add(1, 32'h0001_0040, 3, 1, 0, 0, 0, 0, 0,  4'b0111, 0, 1, 0);
    add(1, 32'h0001_0040, 3, 0, 0, 0, 0, 0, 0,  4'b0111, 0, 1, 0);
    add(1, 32'h0001_0040, 3, 1, 0, 0, 0, 0, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 0, 0, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 0, 0, 0, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 0, 0, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 0, 0, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 1, 0, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 0, 0, 0, 1, 0,  4'b0111, 1, 1, 0);
    add(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,  4'b0000, 0, 0, 0);
    // S5 single beat, then S1 requested back-to-back (one idle cycle forced)
    add(1, 32'h2000_0000, 0, 0, 0, 0, 0, 0, 0,  4'b1101, 0, 1, 0);
    add(1, 32'h2000_0000, 0, 1, 0, 0, 0, 0, 0,  4'b1101, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 1, 0, 0,  4'b1101, 1, 1, 0);
    add(1, 32'h0000_0010, 3, 0, 0, 0, 0, 1, 1,  4'b0000, 0, 0, 0);
    add(1, 32'h0000_0010, 3, 0, 0, 0, 0, 0, 0,  4'b0101, 0, 1, 0);
    // S1 with AWLEN=3 but WLAST on 2nd beat
    add(1, 32'h0000_0010, 3, 1, 0, 0, 0, 0, 0,  4'b0101, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 0, 0, 0,  4'b0101, 1, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 1, 0, 0,  4'b0101, 1, 1, 1);
    add(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,  4'b0000, 0, 0, 1);
    // S3 single beat with correct WLAST; len_err remains sticky
    add(1, 32'h0002_0000, 0, 0, 0, 0, 0, 0, 0,  4'b1001, 0, 1, 1);
    add(1, 32'h0002_0000, 0, 1, 0, 0, 0, 0, 0,  4'b1001, 1, 1, 1);
    add(0, 32'h0,         0, 0, 1, 1, 1, 0, 0,  4'b1001, 1, 1, 1);
    add(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,  4'b0000, 0, 0, 1);
    // S4 at top of its 1 KiB window
    add(1, 32'h1000_03FC, 0, 0, 0, 0, 0, 0, 0,  4'b1011, 0, 1, 1);
    add(1, 32'h1000_03FC, 0, 1, 0, 0, 0, 0, 0,  4'b1011, 1, 1, 1);
    add(0, 32'h0,         0, 0, 1, 1, 1, 0, 0,  4'b1011, 1, 1, 1);
    add(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,  4'b0000, 0, 0, 1);
    // S1 window upper edge is 0x3FFF; 0x4000 is unmapped (checked below)
    add(1, 32'h0000_3FFF, 0, 0, 0, 0, 0, 0, 0,  4'b0101, 0, 1, 1);
    add(1, 32'h0000_3FFF, 0, 1, 0, 0, 0, 0, 0,  4'b0101, 1, 1, 1);
    add(0, 32'h0,         0, 0, 1, 1, 1, 0, 0,  4'b0101, 1, 1, 1);
    add(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,  4'b0000, 0, 0, 1);

    repeat (3) @(negedge ACLK);
    chk("reset_held", 12'h000);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("after_reset_idle", 12'h000);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].av, vq[i].addr, vq[i].len, vq[i].ar, vq[i].wv, vq[i].wr, vq[i].wl, vq[i].bv, vq[i].br);
      @(negedge ACLK);
      chk($sformatf("vec%0d", i), {vq[i].code, vq[i].cs, vq[i].bsy, vq[i].lerr, 5'b00000});
    end

    // Async reset mid-DATA clears everything including sticky len_err
    drive(1, 32'h0001_0040, 3, 1, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    drive(0, 32'h0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge ACLK);
    chk("mid_data", {4'b0111, 1'b1, 1'b1, 1'b1, 5'b00000});
    #2 ARESETn = 1'b0;
    #1 chk("async_reset_in_data", 12'h000);
    drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_async_reset_idle", 12'h000);

`ifdef AXI_DEFSLV_EN
    drive(1, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    chk("def_addr", {4'b1111, 1'b0, 1'b1, 1'b0, 5'b10000});
    drive(1, 32'h3000_0000, 0, 1, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    chk("def_data", {4'b1111, 1'b1, 1'b1, 1'b0, 5'b01000});
    drive(0, 32'h0, 0, 0, 1, 1, 1, 0, 0);
    @(negedge ACLK);
    chk("def_resp", {4'b1111, 1'b1, 1'b1, 1'b0, 5'b00111});
    drive(0, 32'h0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge ACLK);
    chk("def_done", 12'h000);
`else
    drive(1, 32'h3000_0000, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk($sformatf("unmapped_stall%0d", i), 12'h000);
    end
    drive(1, 32'h0000_4000, 0, 1, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    chk("unmapped_s1_edge", 12'h000);
    drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    drive(1, 32'h0001_0000, 0, 0, 0, 0, 0, 0, 0);
    @(negedge ACLK);
    chk("after_withdraw_s2", {4'b0111, 1'b0, 1'b1, 1'b0, 5'b00000});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
